// File: rtl/hamming_syn_seq.sv
// Serial Hamming SEC decoder: scans one codeword bit per cycle, accumulates the
// syndrome, flips the addressed bit and hands the corrected word downstream.

module rca5_m (
    input  logic [4:0] a,
    input  logic [4:0] b,
    input  logic       ci,
    output logic [4:0] s
);
    logic [4:0] w_c;

    // Carry out of the MSB is dropped: callers never count past 31.
    always_comb begin
        w_c    = '0;
        w_c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
        s = a ^ b ^ w_c;
    end
endmodule

module hamming_syn_seq #(
    parameter int N = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] cw_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] cw_out,
    output logic [4:0]   syndrome,
    output logic         err,
    output logic         uncorr,
    output logic         busy
);
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_CORRECT, S_DONE} state_t;

    state_t       r_state;
    logic [4:0]   r_pos;
    logic [4:0]   r_syn;
    logic [N-1:0] r_cw;
    logic         r_err;
    logic         r_uncorr;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_busy;

    logic [4:0]   w_pos_inc;
    logic         w_bit;
    logic         w_syn_hi;
    logic [N-1:0] w_cw_fix;

    rca5_m u_inc (
        .a  (r_pos),
        .b  (5'd1),
        .ci (1'b0),
        .s  (w_pos_inc)
    );

    // Positions are 1-based; select and correction decode them without an adder.
    always_comb begin
        w_bit    = 1'b0;
        w_cw_fix = r_cw;
        for (int p = 1; p <= N; p++) begin
            if (r_pos == 5'(p)) w_bit = r_cw[p-1];
            if (r_syn == 5'(p)) w_cw_fix[p-1] = ~r_cw[p-1];
        end
        w_syn_hi = (r_syn > 5'(N));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pos       <= '0;
            r_syn       <= '0;
            r_cw        <= '0;
            r_err       <= 1'b0;
            r_uncorr    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cw       <= cw_in;
                        r_pos      <= 5'd1;
                        r_syn      <= '0;
                        r_err      <= 1'b0;
                        r_uncorr   <= 1'b0;
                        r_state    <= S_SCAN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_bit) r_syn <= r_syn ^ r_pos;
                    if (r_pos == 5'(N)) r_state <= S_CORRECT;
                    else                r_pos   <= w_pos_inc;
                end
                S_CORRECT: begin
                    if (w_syn_hi) begin
                        r_uncorr <= 1'b1;
                    end else if (r_syn != 5'd0) begin
                        r_cw  <= w_cw_fix;
                        r_err <= 1'b1;
                    end
                    r_state     <= S_DONE;
                    r_out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign cw_out    = r_cw;
    assign syndrome  = r_syn;
    assign err       = r_err;
    assign uncorr    = r_uncorr;
endmodule

// File: tb/tb_hamming_syn_seq.sv
// Bench for hamming_syn_seq: directed vector table, DONE hold, mid-scan reset,
// streaming throughput and random words against a positional-XOR decode model.

module tb_hamming_syn_seq;
    localparam int N = 21;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] cw_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] cw_out;
    logic [4:0]   syndrome;
    logic         err;
    logic         uncorr;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    hamming_syn_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cw_in     (cw_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cw_out    (cw_out),
        .syndrome  (syndrome),
        .err       (err),
        .uncorr    (uncorr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string        name;
        logic [N-1:0] cw;
        logic [N-1:0] exp_cw;
        logic [4:0]   exp_syn;
        logic         exp_err;
        logic         exp_unc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Syndrome is the XOR of the 1-based positions of all set bits.
    function automatic void ref_decode(input logic [N-1:0] cw, output logic [N-1:0] oc,
                                       output logic [4:0] s, output logic e, output logic u);
        int acc = 0;
        for (int p = 1; p <= N; p++) if (cw[p-1]) acc ^= p;
        oc = cw;
        s  = 5'(acc);
        e  = 1'b0;
        u  = 1'b0;
        if (acc != 0 && acc <= N) begin
            oc[acc-1] = ~oc[acc-1];
            e = 1'b1;
        end else if (acc > N) begin
            u = 1'b1;
        end
    endfunction

    function automatic logic [N-1:0] make_valid(input logic [N-1:0] raw);
        logic [N-1:0] w;
        int acc = 0;
        w = raw;
        for (int k = 0; k < 5; k++) w[(1 << k) - 1] = 1'b0;
        for (int p = 1; p <= N; p++) if (w[p-1]) acc ^= p;
        for (int k = 0; k < 5; k++) if (acc[k]) w[(1 << k) - 1] = 1'b1;
        return w;
    endfunction

    function automatic logic [N-1:0] rand_word();
        logic [31:0] r;
        r = $urandom;
        return r[N-1:0];
    endfunction

    task automatic send(input logic [N-1:0] cw);
        int t = 0;
        while (!in_ready && t < 8 * N) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
        end
        in_valid = 1'b1;
        cw_in    = cw;
        @(negedge clk);
        in_valid = 1'b0;
        cw_in    = rand_word();
    endtask

    task automatic wait_valid(output bit ok);
        int t = 0;
        while (!out_valid && t < 8 * N) begin
            @(negedge clk);
            t++;
        end
        ok = out_valid;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL out_valid_timeout actual=0 required=1");
        end
    endtask

    task automatic check_result(input string tag, input logic [N-1:0] ecw, input logic [4:0] es,
                                input logic ee, input logic eu);
        chk({tag, "_cw_out"},   32'(cw_out),   32'(ecw));
        chk({tag, "_syndrome"}, 32'(syndrome), 32'(es));
        chk({tag, "_err"},      32'(err),      32'(ee));
        chk({tag, "_uncorr"},   32'(uncorr),   32'(eu));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t         vt[6];
        bit           ok;
        logic [N-1:0] base, word, ecw;
        logic [4:0]   es;
        logic         ee, eu;
        logic [N-1:0] exp_q[$];
        int           acc_t[$];
        int           cyc, n_acc, n_out;

        vt[0] = '{"zero",      21'h000000, 21'h000000, 5'd0,  1'b0, 1'b0};
        vt[1] = '{"flip5",     21'h000017, 21'h000007, 5'd5,  1'b1, 1'b0};
        vt[2] = '{"p16p8",     21'h008080, 21'h008080, 5'd24, 1'b0, 1'b1};
        vt[3] = '{"flip21",    21'h100000, 21'h000000, 5'd21, 1'b1, 1'b0};
        vt[4] = '{"dbl_alias", 21'h000003, 21'h000007, 5'd3,  1'b1, 1'b0};
        vt[5] = '{"all_ones",  21'h1FFFFF, 21'h1FFFFE, 5'd1,  1'b1, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cw_in     = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_cw_out",    32'(cw_out),    32'd0);
        chk("rst_syndrome",  32'(syndrome),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero word: still busy right after accept, result visible N+2 edges later.
        send('0);
        chk("lat_busy",     32'(busy),     32'd1);
        chk("lat_in_ready", 32'(in_ready), 32'd0);
        repeat (N + 2) @(negedge clk);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        check_result("lat", '0, 5'd0, 1'b0, 1'b0);
        handshake();

        for (int i = 0; i < 6; i++) begin
            send(vt[i].cw);
            wait_valid(ok);
            if (ok) check_result(vt[i].name, vt[i].exp_cw, vt[i].exp_syn, vt[i].exp_err, vt[i].exp_unc);
            handshake();
            chk({vt[i].name, "_idle_after"}, 32'(in_ready), 32'd1);
        end

        // Hold DONE with a competing in_valid that must be ignored.
        send(21'h000017);
        wait_valid(ok);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cw_in = rand_word();
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready",  32'(in_ready),  32'd0);
            check_result("hold", 21'h000007, 5'd5, 1'b1, 1'b0);
        end
        in_valid = 1'b0;
        handshake();
        chk("hold_release_busy", 32'(busy), 32'd0);

        // Reset while pos=10 (edge 0 loads pos=1).
        send(make_valid(rand_word()) ^ 21'h000400);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        word = make_valid(rand_word()) ^ 21'h000200;
        ref_decode(word, ecw, es, ee, eu);
        send(word);
        wait_valid(ok);
        if (ok) check_result("after_rst", ecw, es, ee, eu);
        handshake();

        // Streaming: in_valid and out_ready high, three words.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        n_acc = 0;
        n_out = 0;
        while (n_out < 3 && cyc < 20 * N) begin
            if (out_valid) begin
                if (exp_q.size() > 0) begin
                    ref_decode(exp_q.pop_front(), ecw, es, ee, eu);
                    check_result("stream", ecw, es, ee, eu);
                end
                n_out++;
            end
            if (in_ready && n_acc < 3) begin
                cw_in = (n_acc == 1) ? rand_word() : (make_valid(rand_word()) ^ (21'h1 << $urandom_range(0, N - 1)));
                exp_q.push_back(cw_in);
                acc_t.push_back(cyc);
                n_acc++;
                if (n_acc == 3) begin
                    @(negedge clk);
                    cyc++;
                    in_valid = 1'b0;
                    continue;
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("stream_outputs", 32'(n_out), 32'd3);
        if (acc_t.size() == 3) begin
            chk("stream_gap1", 32'(acc_t[1] - acc_t[0]), 32'(N + 3));
            chk("stream_gap2", 32'(acc_t[2] - acc_t[1]), 32'(N + 3));
        end else begin
            chk("stream_accepts", 32'(acc_t.size()), 32'd3);
        end
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            base = make_valid(rand_word());
            word = base;
            case ($urandom_range(0, 3))
                0: ;
                1: word[$urandom_range(0, N - 1)] ^= 1'b1;
                2: begin
                    word[$urandom_range(0, 9)]      ^= 1'b1;
                    word[$urandom_range(10, N - 1)] ^= 1'b1;
                end
                default: word = rand_word();
            endcase
            ref_decode(word, ecw, es, ee, eu);
            send(word);
            wait_valid(ok);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (ok) check_result("rand", ecw, es, ee, eu);
            handshake();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
